// File: rtl/power_spectrum_seq.sv
// Power-spectrum stage that computes re^2 + im^2 per FFT bin with one shared signed multiplier
// over two cycles. It also provides a ready handshake, bin counting and a sticky frame-length error.
module power_spectrum_seq #(
  parameter int I_BW     = 21,
  parameter int O_BW     = 32,
  parameter int NUM_BINS = 129
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic [2*I_BW-1:0] data_i,
  input  logic              valid_i,
  input  logic              last_i,
  output logic              ready_o,
  output logic [O_BW-1:0]   data_o,
  output logic              valid_o,
  output logic              last_o,
  output logic              frame_err_o
);
  localparam int P_BW  = 2 * I_BW;
  localparam int CNT_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;

  typedef enum logic [1:0] {IDLE, MUL_RE, MUL_IM} state_t;

  typedef struct packed {
    logic signed [I_BW-1:0] re;
    logic signed [I_BW-1:0] im;
    logic                   last;
  } smp_t;

  state_t             state, state_nxt;
  smp_t               smp;
  logic [P_BW-1:0]    acc;
  logic [CNT_W-1:0]   bin_cnt;
  logic signed [I_BW-1:0] op;
  logic signed [P_BW-1:0] prod;
  logic [P_BW-1:0]    sum;
  logic               accept;
  logic               last_bin;

  // The multiplier operand is selected by state so that one multiplier serves both squares.
  assign op       = (state == MUL_RE) ? smp.re : smp.im;
  assign prod     = op * op;
  assign sum      = acc + prod;
  assign ready_o  = rst_n_i & en_i & ((state == IDLE) | (state == MUL_IM));
  assign accept   = valid_i & ready_o;
  assign last_bin = (bin_cnt == CNT_W'(NUM_BINS - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MUL_RE;
      MUL_RE:  state_nxt = MUL_IM;
      MUL_IM:  state_nxt = accept ? MUL_RE : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!en_i) state_nxt = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      smp         <= '0;
      acc         <= '0;
      bin_cnt     <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      last_o      <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      state   <= state_nxt;
      valid_o <= 1'b0;
      if (!en_i) begin
        bin_cnt <= '0;
      end else begin
        // In MUL_IM the im square below reads smp before this update takes effect.
        if (accept) begin
          smp <= '{re: $signed(data_i[P_BW-1:I_BW]), im: $signed(data_i[I_BW-1:0]), last: last_i};
          if (last_i) begin
            if (!last_bin) frame_err_o <= 1'b1;
            bin_cnt <= '0;
          end else if (last_bin) begin
            frame_err_o <= 1'b1;
            bin_cnt     <= '0;
          end else begin
            bin_cnt <= bin_cnt + 1'b1;
          end
        end
        if (state == MUL_RE) acc <= prod;
        if (state == MUL_IM) begin
          data_o  <= O_BW'(sum);
          valid_o <= 1'b1;
          last_o  <= smp.last;
        end
      end
    end
  end
endmodule

// File: tb/tb_power_spectrum_seq.sv
// Directed and randomized bench for power_spectrum_seq, checked against an arithmetic reference
// model that tracks expected outputs, their arrival cycles, frame error state and ready behaviour.
module tb_power_spectrum_seq;
  localparam int NB = 129;

  logic        clk = 1'b0;
  logic        rst_n, en, valid, last, ready;
  logic [41:0] data;
  logic [31:0] dout;
  logic        vout, lout, ferr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {int due; logic [31:0] pw; logic lst;} exp_t;
  exp_t q[$];
  int   m_cnt = 0;
  logic m_err = 1'b0;
  logic acc_prev = 1'b0;

  power_spectrum_seq dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .data_i(data), .valid_i(valid),
    .last_i(last), .ready_o(ready), .data_o(dout), .valid_o(vout), .last_o(lout),
    .frame_err_o(ferr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] power(input logic signed [20:0] re, input logic signed [20:0] im);
    longint p;
    p = longint'(re) * longint'(re) + longint'(im) * longint'(im);
    return p[31:0];
  endfunction

  // Reference model, evaluated between edges where every signal is stable.
  always @(negedge clk) begin
    logic will;
    if (!rst_n) begin
      q.delete();
      m_cnt = 0;
      m_err = 1'b0;
      acc_prev = 1'b0;
      chk("rst_valid", 64'(vout), 64'd0);
    end else begin
      chk("ready", 64'(ready), 64'(en && !acc_prev));
      if (q.size() > 0 && q[0].due == cyc) begin
        chk("out_valid", 64'(vout), 64'd1);
        chk("out_data", 64'(dout), 64'(q[0].pw));
        chk("out_last", 64'(lout), 64'(q[0].lst));
        void'(q.pop_front());
      end else begin
        chk("idle_valid", 64'(vout), 64'd0);
      end
      chk("frame_err", 64'(ferr), 64'(m_err));
      if (!en) begin
        q.delete();
        m_cnt = 0;
      end
      will = valid && ready;
      if (will) begin
        q.push_back('{due: cyc + 3, pw: power(data[41:21], data[20:0]), lst: last});
        if (last) begin
          if (m_cnt != NB - 1) m_err = 1'b1;
          m_cnt = 0;
        end else if (m_cnt == NB - 1) begin
          m_err = 1'b1;
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
      acc_prev = will;
    end
  end

  // Called at posedge+2; returns at posedge+2 right after the accepting edge.
  task automatic send(input logic signed [20:0] re, input logic signed [20:0] im, input logic lst);
    int t;
    valid = 1'b1;
    data  = {re, im};
    last  = lst;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!ready && t < 30);
    chk("send_accept", 64'(ready), 64'd1);
    @(posedge clk);
    #2;
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    logic signed [20:0] r, i;
    rst_n = 1'b0; en = 1'b1; valid = 1'b0; last = 1'b0; data = '0;
    #1;
    chk("reset_data", 64'(dout), 64'd0);
    chk("reset_valid", 64'(vout), 64'd0);
    chk("reset_last", 64'(lout), 64'd0);
    chk("reset_err", 64'(ferr), 64'd0);
    chk("reset_ready", 64'(ready), 64'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // single sample with explicit latency and value
    send(21'sd3, -21'sd4, 1'b0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("single_valid", 64'(vout), 64'd1);
    chk("single_data", 64'(dout), 64'd25);
    chk("single_last", 64'(lout), 64'd0);
    idle(2);

    // back-to-back
    send(21'sd1, 21'sd1, 1'b0);
    send(21'sd2, 21'sd0, 1'b0);
    send(-21'sd5, 21'sd12, 1'b0);
    send(21'sd0, 21'sd0, 1'b0);
    idle(3);

    // extremes
    send(-21'sd1048576, -21'sd1048576, 1'b0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("ext_min", 64'(dout), 64'h0);
    idle(1);
    send(21'sd1048575, 21'sd0, 1'b0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("ext_max", 64'(dout), 64'hFFE00001);
    idle(1);

    // enable dropped right after an accept: flush and clear bin count
    send(21'sd7, 21'sd9, 1'b0);
    en = 1'b0;
    idle(3);
    chk("en_low_valid", 64'(vout), 64'd0);
    en = 1'b1;
    send(21'sd6, -21'sd8, 1'b0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("reenable_data", 64'(dout), 64'd100);
    en = 1'b0;
    idle(1);
    en = 1'b1;
    idle(1);

    // correct frame, then short frame
    for (int k = 0; k < NB; k++) begin
      r = 21'($urandom); i = 21'($urandom);
      send(r, i, k == NB - 1);
    end
    idle(3);
    chk("frame_ok_err", 64'(ferr), 64'd0);
    for (int k = 0; k < 100; k++) begin
      r = 21'($urandom); i = 21'($urandom);
      send(r, i, k == 99);
    end
    idle(3);
    chk("frame_short_err", 64'(ferr), 64'd1);

    // random stream with gaps
    for (int k = 0; k < 80; k++) begin
      r = 21'($urandom); i = 21'($urandom);
      send(r, i, $urandom_range(0, 29) == 0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(3);
    chk("err_sticky", 64'(ferr), 64'd1);

    // async reset while in MUL_RE
    send(21'sd11, 21'sd13, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_data", 64'(dout), 64'd0);
    chk("midrst_valid", 64'(vout), 64'd0);
    chk("midrst_last", 64'(lout), 64'd0);
    chk("midrst_err", 64'(ferr), 64'd0);
    chk("midrst_ready", 64'(ready), 64'd0);
    idle(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_ready", 64'(ready), 64'd1);
    @(posedge clk); #2;
    send(-21'sd20, 21'sd21, 1'b0);
    idle(5);
    chk("drain", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
